wb_dma_engine: RTL and testbench



---
 rtl/wb_dma_engine_if.sv | 30 +++
 rtl/wb_dma_engine.sv | 214 +++++++++++++++++++++
 tb/tb_wb_dma_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dma_engine_if.sv
// -----------------------------------------------------------------------------
// wb_bus
// Classic Wishbone single-transfer bus used by the DMA engine on both sides.
//   cyc, stb, we  : cycle / strobe / write-enable      (initiator -> responder)
//   adr[31:0]     : byte address                        (initiator -> responder)
//   dat_w[31:0]   : write data                          (initiator -> responder)
//   sel[3:0]      : byte selects                        (initiator -> responder)
//   dat_r[31:0]   : read data                           (responder -> initiator)
//   ack           : transfer acknowledge                (responder -> initiator)
// -----------------------------------------------------------------------------
interface wb_bus;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_dma_engine.sv
// -----------------------------------------------------------------------------
// wb_dma_engine
// Memory-to-memory word copy engine. Software programs SRC/DST/LEN/CTRL over
// the responder port; the engine then alternates single read and write beats
// on its initiator port and raises a level interrupt when the run is done.
//
// Ports
//   clk_in      : system clock
//   reset_in    : synchronous, active-low reset
//   bus_slave   : register access (decode on adr[3:2])
//                 0 SRC, 1 DST, 2 LEN, 3 CTRL
//                 CTRL: b0 START(w1) b1 BUSY(ro) b2 DONE(w1c) b3 IRQ_EN b4 ABORT(w1)
//   bus_master  : copy traffic, one classic single transfer at a time
//   irq_out     : DONE & IRQ_EN
// -----------------------------------------------------------------------------
module wb_dma_engine #(
    parameter int LEN_WIDTH = 16
) (
    input  logic  clk_in,
    input  logic  reset_in,
    wb_bus.slave  bus_slave,
    wb_bus.master bus_master,
    output logic  irq_out
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [31:0]          WORD_STEP = 32'd4;

    // Programming registers
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_done;
    logic                 r_irq_en;
    logic                 r_abort_pend;

    // Working copies used by the running transfer
    state_t               r_state;
    logic [31:0]          r_cur_src;
    logic [31:0]          r_cur_dst;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [31:0]          r_buf;

    // Responder outputs
    logic                 r_s_ack;
    logic [31:0]          r_s_dat;

    // Initiator outputs
    logic                 r_m_cyc;
    logic                 r_m_we;
    logic [31:0]          r_m_adr;
    logic [31:0]          r_m_dat;
    logic [3:0]           r_m_sel;

    logic                 w_busy;
    logic                 w_req;
    logic                 w_wr;
    logic                 w_ctrl_wr;
    logic                 w_start;
    logic                 w_abort;
    logic [1:0]           w_reg_idx;
    logic [31:0]          w_rd_data;
    logic                 w_unused_bits;

    assign w_busy    = (r_state != ST_IDLE);
    // A request is only taken while ack is low, which enforces one idle
    // cycle between consecutive acks.
    assign w_req     = bus_slave.cyc & bus_slave.stb & ~r_s_ack;
    assign w_wr      = w_req & bus_slave.we;
    assign w_reg_idx = bus_slave.adr[3:2];
    assign w_ctrl_wr = w_wr & (w_reg_idx == 2'd3);
    assign w_start   = w_ctrl_wr & bus_slave.dat_w[0] & ~w_busy;
    assign w_abort   = w_ctrl_wr & bus_slave.dat_w[4] & w_busy;

    // Only adr[3:2] decodes and every access is a full word.
    assign w_unused_bits = ^{bus_slave.sel, bus_slave.adr[31:4], bus_slave.adr[1:0]};

    always_comb begin
        w_rd_data = '0;
        case (w_reg_idx)
            2'd0:    w_rd_data = r_src;
            2'd1:    w_rd_data = r_dst;
            2'd2:    w_rd_data = {{(32-LEN_WIDTH){1'b0}}, r_len};
            default: w_rd_data = {27'd0, 1'b0, r_irq_en, r_done, w_busy, 1'b0};
        endcase
    end

    assign bus_slave.ack    = r_s_ack;
    assign bus_slave.dat_r  = r_s_dat;
    assign bus_master.cyc   = r_m_cyc;
    assign bus_master.stb   = r_m_cyc;
    assign bus_master.we    = r_m_we;
    assign bus_master.adr   = r_m_adr;
    assign bus_master.dat_w = r_m_dat;
    assign bus_master.sel   = r_m_sel;
    assign irq_out          = r_done & r_irq_en;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_done       <= 1'b0;
            r_irq_en     <= 1'b0;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
            r_cur_src    <= '0;
            r_cur_dst    <= '0;
            r_remaining  <= '0;
            r_buf        <= '0;
            r_s_ack      <= 1'b0;
            r_s_dat      <= '0;
            r_m_cyc      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_adr      <= '0;
            r_m_dat      <= '0;
            r_m_sel      <= '0;
        end else begin
            // ---------------- register responder ----------------
            r_s_ack <= w_req;
            if (w_req && !bus_slave.we) begin
                r_s_dat <= w_rd_data;
            end

            if (w_wr) begin
                case (w_reg_idx)
                    2'd0: if (!w_busy) r_src <= {bus_slave.dat_w[31:2], 2'b00};
                    2'd1: if (!w_busy) r_dst <= {bus_slave.dat_w[31:2], 2'b00};
                    2'd2: if (!w_busy) r_len <= bus_slave.dat_w[LEN_WIDTH-1:0];
                    default: begin
                        r_irq_en <= bus_slave.dat_w[3];
                        if (bus_slave.dat_w[2]) begin
                            r_done <= 1'b0;
                        end
                    end
                endcase
            end

            if (w_abort) begin
                r_abort_pend <= 1'b1;
            end

            // ---------------- copy initiator ----------------
            // Assignments below come after the W1C above so that a DONE set
            // in FIN wins over a clear in the same cycle.
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_done       <= 1'b0;
                        r_cur_src    <= r_src;
                        r_cur_dst    <= r_dst;
                        r_remaining  <= r_len;
                        r_abort_pend <= 1'b0;
                        r_state      <= (r_len == '0) ? ST_FIN : ST_RD;
                    end
                end

                // Each beat state spends its first cycle with cyc low, which
                // gives the mandatory idle cycle between consecutive beats.
                ST_RD: begin
                    if (!r_m_cyc) begin
                        r_m_cyc <= 1'b1;
                        r_m_we  <= 1'b0;
                        r_m_adr <= r_cur_src;
                        r_m_sel <= 4'hF;
                    end else if (bus_master.ack) begin
                        r_buf   <= bus_master.dat_r;
                        r_m_cyc <= 1'b0;
                        r_m_sel <= 4'h0;
                        r_state <= ST_WR;
                    end
                end

                ST_WR: begin
                    if (!r_m_cyc) begin
                        r_m_cyc <= 1'b1;
                        r_m_we  <= 1'b1;
                        r_m_adr <= r_cur_dst;
                        r_m_dat <= r_buf;
                        r_m_sel <= 4'hF;
                    end else if (bus_master.ack) begin
                        r_m_cyc     <= 1'b0;
                        r_m_we      <= 1'b0;
                        r_m_sel     <= 4'h0;
                        r_cur_src   <= r_cur_src + WORD_STEP;
                        r_cur_dst   <= r_cur_dst + WORD_STEP;
                        r_remaining <= r_remaining - LEN_ONE;
                        // Abort is honoured only at a pair boundary, so a
                        // read already under way always gets its write.
                        if (r_remaining == LEN_ONE || r_abort_pend || w_abort) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end

                default: begin
                    if (!r_abort_pend) begin
                        r_done <= 1'b1;
                    end
                    r_abort_pend <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_engine
// Drives the register port like a CPU, serves copy traffic from a sparse
// memory model with configurable latency, and compares the observed beats
// and memory contents against the expected copy computed from SRC/DST/LEN.
// -----------------------------------------------------------------------------
module tb_wb_dma_engine;
    localparam int LEN_WIDTH = 16;

    localparam logic [31:0] C_START = 32'h01;
    localparam logic [31:0] C_DONE  = 32'h04;
    localparam logic [31:0] C_IRQEN = 32'h08;
    localparam logic [31:0] C_ABORT = 32'h10;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;

    always #5 clk = ~clk;

    wb_bus cpu_bus ();
    wb_bus mem_bus ();

    wb_dma_engine #(.LEN_WIDTH(LEN_WIDTH)) dut (
        .clk_in     (clk),
        .reset_in   (rst_n),
        .bus_slave  (cpu_bus),
        .bus_master (mem_bus),
        .irq_out    (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- memory model on the copy port ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    logic [31:0] mem [logic [31:0]];
    beat_t       beat_log [$];
    int          mem_lat    = 0;
    int          cyc_cycles = 0;
    int          gap_errs   = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hDEAD0000 ^ a);
    endfunction

    initial begin : mem_model
        int    wait_cnt;
        beat_t b;
        wait_cnt      = 0;
        mem_bus.ack   = 1'b0;
        mem_bus.dat_r = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_bus.ack) begin
                mem_bus.ack = 1'b0;
                wait_cnt    = 0;
                // The engine must have dropped cyc at the edge that saw ack.
                if (mem_bus.cyc) gap_errs++;
            end else if (mem_bus.cyc && mem_bus.stb) begin
                cyc_cycles++;
                if (wait_cnt >= mem_lat) begin
                    b.we  = mem_bus.we;
                    b.adr = mem_bus.adr;
                    if (mem_bus.we) begin
                        mem[mem_bus.adr] = mem_bus.dat_w;
                        b.dat = mem_bus.dat_w;
                    end else begin
                        mem_bus.dat_r = mem_rd(mem_bus.adr);
                        b.dat = mem_bus.dat_r;
                    end
                    beat_log.push_back(b);
                    mem_bus.ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- CPU side ----------------
    task automatic cpu_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
        @(posedge clk);
        #1;
        cpu_bus.cyc   = 1'b1;
        cpu_bus.stb   = 1'b1;
        cpu_bus.we    = we;
        cpu_bus.adr   = {28'($urandom()), idx, 2'b00};
        cpu_bus.dat_w = wd;
        cpu_bus.sel   = 4'hF;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!cpu_bus.ack && lat < 20);
        rd = cpu_bus.dat_r;
        if (!cpu_bus.ack) check_val("cpu_ack_timeout", 32'(cpu_bus.ack), 32'd1);
        cpu_bus.cyc = 1'b0;
        cpu_bus.stb = 1'b0;
        cpu_bus.we  = 1'b0;
        $display("cpu %s reg%0d wd=%h rd=%h lat=%0d", we ? "wr" : "rd", idx, wd, rd, lat);
    endtask

    task automatic reg_wr(input logic [1:0] idx, input logic [31:0] d);
        logic [31:0] unused_rd;
        int          lat;
        cpu_xfer(1'b1, idx, d, unused_rd, lat);
    endtask

    task automatic reg_rd(input logic [1:0] idx, output logic [31:0] d);
        int lat;
        cpu_xfer(1'b0, idx, 32'd0, d, lat);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        int          n;
        n = 0;
        do begin
            reg_rd(2'd3, v);
            n++;
        end while (v[1] && n < 300);
        if (v[1]) check_val({tag, " idle_timeout"}, 32'(v[1]), 32'd0);
    endtask

    task automatic fill(input logic [31:0] base, input int words);
        for (int i = 0; i < words; i++) mem[base + 32'(4 * i)] = $urandom();
    endtask

    // Expected copy: word i is read from src+4i then written to dst+4i.
    task automatic verify_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                               input int words);
        logic [31:0] sa;
        logic [31:0] da;
        check_val({tag, " beats"}, 32'(beat_log.size()), 32'(2 * words));
        for (int i = 0; i < words; i++) begin
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            if (beat_log.size() >= 2 * i + 2) begin
                check_val({tag, " rd_we"},  32'(beat_log[2*i].we),    32'd0);
                check_val({tag, " rd_adr"}, beat_log[2*i].adr,        sa);
                check_val({tag, " rd_dat"}, beat_log[2*i].dat,        mem_rd(sa));
                check_val({tag, " wr_we"},  32'(beat_log[2*i+1].we),  32'd1);
                check_val({tag, " wr_adr"}, beat_log[2*i+1].adr,      da);
                check_val({tag, " wr_dat"}, beat_log[2*i+1].dat,      mem_rd(sa));
            end
            check_val({tag, " mem"}, mem_rd(da), mem_rd(sa));
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] v;
        logic [31:0] src;
        logic [31:0] dst;
        int          lat;
        int          n;
        int          words;
        int          cyc0;
        logic        ien;

        rst_n         = 1'b0;
        cpu_bus.cyc   = 1'b0;
        cpu_bus.stb   = 1'b0;
        cpu_bus.we    = 1'b0;
        cpu_bus.adr   = '0;
        cpu_bus.dat_w = '0;
        cpu_bus.sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst irq", 32'(irq), 32'd0);
        check_val("rst m_cyc", 32'(mem_bus.cyc), 32'd0);
        check_val("rst m_adr", mem_bus.adr, 32'd0);
        check_val("rst s_ack", 32'(cpu_bus.ack), 32'd0);
        check_val("rst s_dat", cpu_bus.dat_r, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reg_rd(2'(i), v);
            check_val("rst reg", v, 32'd0);
        end

        // ---- register access ----
        cpu_xfer(1'b1, 2'd0, 32'h0000_3003, v, lat); check_val("reg ack_lat", 32'(lat), 32'd1);
        cpu_xfer(1'b1, 2'd1, 32'h0000_3100, v, lat); check_val("reg ack_lat", 32'(lat), 32'd1);
        cpu_xfer(1'b1, 2'd2, 32'hABCD_0004, v, lat); check_val("reg ack_lat", 32'(lat), 32'd1);
        cpu_xfer(1'b1, 2'd3, C_IRQEN,       v, lat); check_val("reg ack_lat", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        check_val("reg ack_single", 32'(cpu_bus.ack), 32'd0);
        cpu_xfer(1'b0, 2'd0, 32'd0, v, lat); check_val("reg src", v, 32'h3000); check_val("reg ack_lat", 32'(lat), 32'd1);
        cpu_xfer(1'b0, 2'd1, 32'd0, v, lat); check_val("reg dst", v, 32'h3100);
        cpu_xfer(1'b0, 2'd2, 32'd0, v, lat); check_val("reg len", v, 32'h4);
        cpu_xfer(1'b0, 2'd3, 32'd0, v, lat); check_val("reg ctrl", v, C_IRQEN);

        // ---- basic copy ----
        for (int i = 0; i < 4; i++) mem[32'h3000 + 32'(4 * i)] = 32'hA0 + 32'(i);
        mem_lat = 1;
        beat_log.delete();
        reg_wr(2'd3, C_IRQEN | C_START);
        wait_idle("basic");
        verify_copy("basic", 32'h3000, 32'h3100, 4);
        for (int i = 0; i < 4; i++) check_val("basic dst_val", mem_rd(32'h3100 + 32'(4 * i)), 32'hA0 + 32'(i));
        reg_rd(2'd3, v);
        check_val("basic ctrl", v, C_DONE | C_IRQEN);
        check_val("basic irq", 32'(irq), 32'd1);
        reg_wr(2'd3, C_IRQEN | C_DONE);
        check_val("basic irq_w1c", 32'(irq), 32'd0);
        reg_rd(2'd3, v);
        check_val("basic ctrl_w1c", v, C_IRQEN);

        // ---- zero length ----
        reg_wr(2'd2, 32'd0);
        cyc0 = cyc_cycles;
        cpu_xfer(1'b1, 2'd3, C_IRQEN | C_START, v, lat);
        check_val("len0 irq_at_ack", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        check_val("len0 irq_next", 32'(irq), 32'd1);
        reg_rd(2'd3, v);
        check_val("len0 ctrl", v, C_DONE | C_IRQEN);
        check_val("len0 no_cycles", 32'(cyc_cycles), 32'(cyc0));
        reg_wr(2'd3, C_DONE);
        reg_rd(2'd3, v);
        check_val("len0 ctrl_clr", v, 32'd0);

        // ---- abort during read of word 1 ----
        src = 32'h6000;
        dst = 32'h6100;
        fill(src, 8);
        for (int i = 0; i < 8; i++) mem[dst + 32'(4 * i)] = 32'h5A5A_0000 + 32'(i);
        mem_lat = 8;
        beat_log.delete();
        reg_wr(2'd0, src);
        reg_wr(2'd1, dst);
        reg_wr(2'd2, 32'd8);
        reg_wr(2'd3, C_START);
        n = 0;
        while (beat_log.size() < 2 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val("abort second_beat", 32'(beat_log.size() >= 2), 32'd1);
        @(posedge clk);
        #1;
        reg_wr(2'd3, C_ABORT);
        wait_idle("abort");
        verify_copy("abort", src, dst, 2);
        for (int i = 2; i < 8; i++) check_val("abort untouched", mem_rd(dst + 32'(4 * i)), 32'h5A5A_0000 + 32'(i));
        reg_rd(2'd3, v);
        check_val("abort ctrl", v, 32'd0);
        reg_rd(2'd1, v);
        check_val("abort dst_reg", v, dst);
        check_val("abort irq", 32'(irq), 32'd0);

        // ---- busy protection ----
        src = 32'h7000;
        dst = 32'h7100;
        fill(src, 4);
        mem_lat = 3;
        beat_log.delete();
        reg_wr(2'd0, src);
        reg_wr(2'd1, dst);
        reg_wr(2'd2, 32'd4);
        reg_wr(2'd3, C_START);
        cpu_xfer(1'b1, 2'd2, 32'd100, v, lat); check_val("busy len_ack", 32'(lat), 32'd1);
        cpu_xfer(1'b1, 2'd3, C_START, v, lat); check_val("busy start_ack", 32'(lat), 32'd1);
        reg_wr(2'd0, 32'h9999_0000);
        reg_rd(2'd3, v);
        check_val("busy busy_bit", v & 32'h2, 32'h2);
        wait_idle("busy");
        verify_copy("busy", src, dst, 4);
        reg_rd(2'd2, v);
        check_val("busy len_reg", v, 32'd4);
        reg_rd(2'd0, v);
        check_val("busy src_reg", v, src);
        reg_rd(2'd3, v);
        check_val("busy ctrl", v, C_DONE);

        // ---- randomized copies ----
        for (int t = 0; t < 6; t++) begin
            src     = 32'h1000_0000 + 32'($urandom_range(0, 1023) * 4);
            dst     = 32'h2000_0000 + 32'($urandom_range(0, 1023) * 4);
            words   = $urandom_range(1, 6);
            ien     = 1'($urandom_range(0, 1));
            mem_lat = $urandom_range(0, 3);
            fill(src, words);
            beat_log.delete();
            reg_wr(2'd0, src);
            reg_wr(2'd1, dst);
            reg_wr(2'd2, 32'(words));
            reg_wr(2'd3, C_START | (ien ? C_IRQEN : 32'd0));
            wait_idle("rand");
            verify_copy("rand", src, dst, words);
            reg_rd(2'd3, v);
            check_val("rand ctrl", v, C_DONE | (ien ? C_IRQEN : 32'd0));
            check_val("rand irq", 32'(irq), 32'(ien));
            reg_wr(2'd3, C_DONE);
        end

        // ---- address wrap ----
        src = 32'hFFFF_FFFC;
        dst = 32'h4000;
        fill(src, 2);
        mem_lat = 0;
        beat_log.delete();
        reg_wr(2'd0, src);
        reg_wr(2'd1, dst);
        reg_wr(2'd2, 32'd2);
        reg_wr(2'd3, C_START);
        wait_idle("wrap");
        verify_copy("wrap", src, dst, 2);
        if (beat_log.size() >= 3) check_val("wrap second_rd_adr", beat_log[2].adr, 32'h0);

        // ---- reset in the middle of a write beat ----
        mem_lat = 6;
        beat_log.delete();
        reg_wr(2'd0, 32'h5000);
        reg_wr(2'd1, 32'h5100);
        reg_wr(2'd2, 32'd4);
        reg_wr(2'd3, C_IRQEN | C_START);
        n = 0;
        while (!(mem_bus.cyc && mem_bus.we) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("rst reach_wr", 32'(mem_bus.cyc & mem_bus.we), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst cyc_drop", 32'(mem_bus.cyc), 32'd0);
        check_val("rst we_drop", 32'(mem_bus.we), 32'd0);
        check_val("rst adr_clr", mem_bus.adr, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reg_rd(2'(i), v);
            check_val("rst mid_reg", v, 32'd0);
        end
        check_val("rst mid_irq", 32'(irq), 32'd0);

        check_val("mem gap", 32'(gap_errs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
